// File: rtl/seq_pkg.sv
// Shared constants, mode encoding and the wrap-around step rule
// used by the LED state sequencer.
package seq_pkg;

    localparam int STATE_W    = 3;
    localparam int NUM_STATES = 5;
    localparam logic [STATE_W-1:0] LAST_STATE = 3'd4;

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_AUTO   = 1'b1
    } mode_e;

    // Next sequence position; an out-of-range value recovers to 0 whatever the direction.
    function automatic logic [STATE_W-1:0] next_state(input logic [STATE_W-1:0] cur,
                                                      input logic              down);
        if (cur > LAST_STATE) begin
            return '0;
        end
        if (down) begin
            return (cur == '0) ? LAST_STATE : cur - STATE_W'(1);
        end
        return (cur == LAST_STATE) ? '0 : cur + STATE_W'(1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw push button conditioning: 2-flop synchronizer, hold-time debounce
// counter and a single-cycle pulse on each accepted press.
module btn_debounce #(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn,
    output logic press
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             level;
    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // Level held long enough; only the 0->1 acceptance is an event.
                cnt   <= '0;
                level <= sync2;
                press <= sync2;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/state_sequencer.sv
// Five-position sequencer stepped by a debounced button (MANUAL) or a
// prescaled tick (AUTO), with direction and run/freeze control.
module state_sequencer
    import seq_pkg::*;
#(
    parameter int TICK_DIV   = 50_000_000,
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               btn_next,
    input  logic               btn_mode,
    input  logic               dir,
    input  logic               enable,
    output logic [STATE_W-1:0] state,
    output logic               step,
    output logic               auto
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic             next_press;
    logic             mode_press;
    logic             dir_s1;
    logic             dir_s2;
    logic             step_req;
    mode_e            mode;
    logic [PRE_W-1:0] prescaler;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_next_deb (
        .clk     (clk),
        .reset_n (reset_n),
        .btn     (btn_next),
        .press   (next_press)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_mode_deb (
        .clk     (clk),
        .reset_n (reset_n),
        .btn     (btn_mode),
        .press   (mode_press)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dir_s1 <= 1'b0;
            dir_s2 <= 1'b0;
        end else begin
            dir_s1 <= dir;
            dir_s2 <= dir_s1;
        end
    end

    // Step source follows the mode in force before any toggle this cycle.
    always_comb begin
        // NOTE: default assigned first so no branch can leave step_req unassigned and infer a latch.
        step_req = 1'b0;
        if (mode == MODE_AUTO) begin
            step_req = (prescaler == PRE_LAST);
        end else begin
            step_req = next_press;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode      <= MODE_MANUAL;
            auto      <= 1'b0;
            prescaler <= '0;
            state     <= '0;
            step      <= 1'b0;
        end else begin
            step <= 1'b0;
            // Frozen cycles drop any press event instead of queueing it.
            if (enable) begin
                if (step_req) begin
                    state <= next_state(state, dir_s2);
                    step  <= 1'b1;
                end
                if (mode_press) begin
                    mode      <= (mode == MODE_MANUAL) ? MODE_AUTO : MODE_MANUAL;
                    auto      <= (mode == MODE_MANUAL);
                    prescaler <= '0;
                end else if (mode == MODE_AUTO) begin
                    prescaler <= (prescaler == PRE_LAST) ? '0 : prescaler + PRE_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_state_sequencer.sv
// Directed scoreboard bench for state_sequencer (TICK_DIV=3, DEB_CYCLES=4).
module tb_state_sequencer;

    localparam int TICK_DIV   = 3;
    localparam int DEB_CYCLES = 4;
    localparam int LAT        = DEB_CYCLES + 3;

    typedef struct {
        logic [2:0] state;
        logic       auto_m;
        int         cycle;
    } exp_t;

    logic       clk;
    logic       reset_n;
    logic       btn_next;
    logic       btn_mode;
    logic       dir;
    logic       enable;
    logic [2:0] state;
    logic       step;
    logic       auto;

    int   cyc;
    int   n_checks;
    int   n_errors;
    exp_t sb[$];

    state_sequencer #(.TICK_DIV(TICK_DIV), .DEB_CYCLES(DEB_CYCLES)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .btn_next (btn_next),
        .btn_mode (btn_mode),
        .dir      (dir),
        .enable   (enable),
        .state    (state),
        .step     (step),
        .auto     (auto)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic push_exp(input logic [2:0] s, input logic a, input int c);
        exp_t e;
        e.state  = s;
        e.auto_m = a;
        e.cycle  = c;
        sb.push_back(e);
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every step pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (reset_n && step) begin
            if (sb.size() == 0) begin
                check("unexpected_step", 32'(state), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("step_state", 32'(state), 32'(e.state));
                check("step_auto", 32'(auto), 32'(e.auto_m));
                check("step_cycle", 32'(cyc), 32'(e.cycle));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] up_seq [5];
        int c0;
        int m0;
        up_seq = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
        n_checks = 0;
        n_errors = 0;

        reset_n  = 1'b0;
        btn_next = 1'b0;
        btn_mode = 1'b0;
        dir      = 1'b0;
        enable   = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_state", 32'(state), 32'd0);
        check("reset_step", 32'(step), 32'd0);
        check("reset_auto", 32'(auto), 32'd0);
        reset_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end

        // Five clean presses, MANUAL, counting up with wrap 4->0.
        for (int i = 0; i < 5; i++) begin
            c0 = cyc;
            btn_next = 1'b1;
            push_exp(up_seq[i], 1'b0, c0 + LAT);
            wait_until(c0 + 10);
            btn_next = 1'b0;
            wait_until(c0 + 20);
        end

        // Bouncing 1,0,1 then held: one step timed from the final rise.
        c0 = cyc;
        btn_next = 1'b1;
        wait_until(c0 + 2);
        btn_next = 1'b0;
        wait_until(c0 + 4);
        btn_next = 1'b1;
        push_exp(3'd1, 1'b0, c0 + 4 + LAT);
        wait_until(c0 + 15);
        btn_next = 1'b0;
        wait_until(c0 + 25);

        // Manual step down 1->0.
        dir = 1'b1;
        wait_until(cyc + 3);
        c0 = cyc;
        btn_next = 1'b1;
        push_exp(3'd0, 1'b0, c0 + LAT);
        wait_until(c0 + 10);
        btn_next = 1'b0;
        wait_until(c0 + 20);

        // AUTO, counting down from 0 every TICK_DIV cycles; btn_next ignored.
        m0 = cyc;
        btn_mode = 1'b1;
        push_exp(3'd4, 1'b1, m0 + LAT + 3);
        push_exp(3'd3, 1'b1, m0 + LAT + 6);
        push_exp(3'd2, 1'b1, m0 + LAT + 9);
        push_exp(3'd1, 1'b1, m0 + LAT + 12);
        push_exp(3'd0, 1'b1, m0 + LAT + 15);
        wait_until(m0 + 1);
        btn_next = 1'b1;
        wait_until(m0 + 12);
        btn_next = 1'b0;
        btn_mode = 1'b0;

        // Freeze for 10 edges with prescaler at 1; a mode press lands while frozen.
        wait_until(m0 + 23);
        enable = 1'b0;
        wait_until(m0 + 24);
        btn_mode = 1'b1;
        wait_until(m0 + 30);
        check("frozen_state", 32'(state), 32'd0);
        check("frozen_auto", 32'(auto), 32'd1);
        wait_until(m0 + 32);
        btn_mode = 1'b0;
        wait_until(m0 + 33);
        enable = 1'b1;
        push_exp(3'd4, 1'b1, m0 + 35);
        push_exp(3'd3, 1'b1, m0 + 38);

        // Asynchronous reset pulse at state 3 with a press mid-debounce.
        wait_until(m0 + 37);
        btn_next = 1'b1;
        wait_until(m0 + 39);
        check("pre_reset_state", 32'(state), 32'd3);
        #1;
        reset_n  = 1'b0;
        btn_next = 1'b0;
        #1;
        check("async_reset_state", 32'(state), 32'd0);
        check("async_reset_auto", 32'(auto), 32'd0);
        check("async_reset_step", 32'(step), 32'd0);
        #1;
        reset_n = 1'b1;
        wait_until(cyc + 20);
        check("post_reset_state", 32'(state), 32'd0);
        check("post_reset_auto", 32'(auto), 32'd0);

        // Simultaneous mode and next presses in MANUAL: one step, then AUTO.
        dir = 1'b0;
        wait_until(cyc + 3);
        c0 = cyc;
        btn_next = 1'b1;
        btn_mode = 1'b1;
        push_exp(3'd1, 1'b1, c0 + LAT);
        wait_until(c0 + LAT + 1);
        enable = 1'b0;
        wait_until(c0 + 10);
        btn_next = 1'b0;
        btn_mode = 1'b0;
        wait_until(c0 + 25);
        check("final_state", 32'(state), 32'd1);
        check("final_auto", 32'(auto), 32'd1);
        check("final_step", 32'(step), 32'd0);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
